// File: rtl/cpu_pkg.sv
// Shared decode constants, issue bundle type and opcode classification for the
// decode/register-read stage.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // Control half of the issued bundle; rd is kept because {rd,shamt,funct} is imm16.
  typedef struct packed {
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [4:0]            shamt;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] dest;
    logic                  illegal;
  } issue_bundle_t;

  typedef struct packed {
    logic                  reads_rs;
    logic                  reads_rt;
    logic [REG_ADDR_W-1:0] dest;
    logic                  illegal;
  } decode_t;

  function automatic decode_t decode_op(input logic [5:0] opcode,
                                        input logic [REG_ADDR_W-1:0] rt,
                                        input logic [REG_ADDR_W-1:0] rd);
    decode_t d;
    d = '0;
    case (opcode)
      OP_RTYPE: begin
        d.reads_rs = 1'b1;
        d.reads_rt = 1'b1;
        d.dest     = rd;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
        d.reads_rs = 1'b1;
        d.dest     = rt;
      end
      OP_SW, OP_BEQ: begin
        d.reads_rs = 1'b1;
        d.reads_rt = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// Decoded-instruction input, writeback port and execute-side issue handshake.
// master = upstream/writeback/execute side, slave = the decode/issue stage.
interface decode_issue_stage_if #(parameter int DATA_W = 32);

  logic              in_valid;
  logic              in_ready;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;

  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              ex_valid;
  logic              ex_ready;
  logic [5:0]        ex_opcode;
  logic [5:0]        ex_funct;
  logic [4:0]        ex_shamt;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_dest;
  logic              ex_illegal;

  modport master (
    output in_valid, opcode, rs, rt, rd, shamt, funct,
    output wb_en, wb_addr, wb_data,
    output ex_ready,
    input  in_ready,
    input  ex_valid, ex_opcode, ex_funct, ex_shamt, ex_a, ex_b, ex_imm, ex_dest, ex_illegal
  );

  modport slave (
    input  in_valid, opcode, rs, rt, rd, shamt, funct,
    input  wb_en, wb_addr, wb_data,
    input  ex_ready,
    output in_ready,
    output ex_valid, ex_opcode, ex_funct, ex_shamt, ex_a, ex_b, ex_imm, ex_dest, ex_illegal
  );

endinterface

// File: rtl/decode_issue_stage_regfile_2r1w.sv
// Register file: two combinational read ports, one clocked write port,
// asynchronous reset, r0 hardwired to zero.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0]     ra_data,
  input  logic [REG_ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0]     rb_data,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0]     wd
);

  logic [DATA_W-1:0] regs [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_flop
        logic [DATA_W-1:0] q_reg;
        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            q_reg <= '0;
          end else if (we && wa == REG_ADDR_W'(gi)) begin
            q_reg <= wd;
          end
        end
        assign regs[gi] = q_reg;
      end
    end
  endgenerate

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/register-read/issue stage with RAW/WAW scoreboard and one-deep output register.
// Optional build macro WB_BYPASS_EN: same-cycle writeback forwarding into the issued operands.
module decode_issue_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input logic               clock,
  input logic               reset,
  decode_issue_stage_if.slave bus
);

  decode_t           dec;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [NREGS-1:0]  sb_reg;
  logic [NREGS-1:0]  sb_next;
  logic [NREGS-1:0]  sb_eff;
  logic [NREGS-1:0]  wb_clr;
  logic              wb_fire;
  logic              hazard;
  logic              out_free;
  logic              accept;

  issue_bundle_t     bundle_reg, bundle_next;
  logic [DATA_W-1:0] a_reg, a_next;
  logic [DATA_W-1:0] b_reg, b_next;
  logic              ex_valid_reg, ex_valid_next;

  assign dec = decode_op(bus.opcode, bus.rt, bus.rd);

  regfile_2r1w #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .ra_addr (bus.rs),
    .ra_data (rf_a),
    .rb_addr (bus.rt),
    .rb_data (rf_b),
    .we      (wb_fire),
    .wa      (bus.wb_addr),
    .wd      (bus.wb_data)
  );

  assign wb_fire = bus.wb_en && (bus.wb_addr != '0);

  always_comb begin
    wb_clr = '0;
    if (wb_fire) wb_clr[bus.wb_addr] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  // A writeback landing this cycle already resolves its pending bit and supplies the value.
  assign sb_eff = sb_reg & ~wb_clr;
  assign op_a   = (wb_fire && bus.wb_addr == bus.rs) ? bus.wb_data : rf_a;
  assign op_b   = (wb_fire && bus.wb_addr == bus.rt) ? bus.wb_data : rf_b;
`else
  assign sb_eff = sb_reg;
  assign op_a   = rf_a;
  assign op_b   = rf_b;
`endif

  // sb_reg[0] is never set, so r0 sources and dest=0 can never raise a hazard.
  assign hazard   = (dec.reads_rs && sb_eff[bus.rs]) ||
                    (dec.reads_rt && sb_eff[bus.rt]) ||
                    ((dec.dest != '0) && sb_eff[dec.dest]);
  assign out_free = !ex_valid_reg || bus.ex_ready;
  assign accept   = bus.in_valid && out_free && !hazard;
  assign bus.in_ready = out_free && !hazard;

  // Clear from writeback first, then set from issue, so a same-edge set wins.
  always_comb begin
    sb_next = sb_reg & ~wb_clr;
    if (accept && dec.dest != '0) sb_next[dec.dest] = 1'b1;
  end

  // Operands for sources the opcode does not read are issued as zero.
  always_comb begin
    ex_valid_next = ex_valid_reg;
    bundle_next   = bundle_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    if (accept) begin
      ex_valid_next       = 1'b1;
      bundle_next.opcode  = bus.opcode;
      bundle_next.funct   = bus.funct;
      bundle_next.shamt   = bus.shamt;
      bundle_next.rd      = bus.rd;
      bundle_next.dest    = dec.dest;
      bundle_next.illegal = dec.illegal;
      a_next              = dec.reads_rs ? op_a : '0;
      b_next              = dec.reads_rt ? op_b : '0;
    end else if (out_free) begin
      ex_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sb_reg       <= '0;
      ex_valid_reg <= 1'b0;
      bundle_reg   <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
    end else begin
      sb_reg       <= sb_next;
      ex_valid_reg <= ex_valid_next;
      bundle_reg   <= bundle_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
    end
  end

  assign bus.ex_valid   = ex_valid_reg;
  assign bus.ex_opcode  = bundle_reg.opcode;
  assign bus.ex_funct   = bundle_reg.funct;
  assign bus.ex_shamt   = bundle_reg.shamt;
  assign bus.ex_a       = a_reg;
  assign bus.ex_b       = b_reg;
  assign bus.ex_imm     = {{(DATA_W-16){bundle_reg.rd[4]}}, bundle_reg.rd,
                           bundle_reg.shamt, bundle_reg.funct};
  assign bus.ex_dest    = bundle_reg.dest;
  assign bus.ex_illegal = bundle_reg.illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed scoreboard bench for decode_issue_stage: expected bundles are queued at
// acceptance and popped by a monitor whenever execute takes a bundle.
module tb_decode_issue_stage;
  import cpu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  decode_issue_stage_if #(.DATA_W(32)) bus();

  decode_issue_stage #(.DATA_W(32), .NREGS(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

`ifdef WB_BYPASS_EN
  localparam int WB_STALLS = 2;
`else
  localparam int WB_STALLS = 3;
`endif

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic expect_bundle(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] sh,
                               input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] dest, input logic ill);
    exp_t e;
    e.opcode  = op;
    e.funct   = fn;
    e.shamt   = sh;
    e.a       = a;
    e.b       = b;
    e.imm     = {{16{rd[4]}}, rd, sh, fn};
    e.dest    = dest;
    e.illegal = ill;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t g;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && bus.ex_valid && bus.ex_ready) begin
        g.opcode  = bus.ex_opcode;
        g.funct   = bus.ex_funct;
        g.shamt   = bus.ex_shamt;
        g.a       = bus.ex_a;
        g.b       = bus.ex_b;
        g.imm     = bus.ex_imm;
        g.dest    = bus.ex_dest;
        g.illegal = bus.ex_illegal;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_bundle: got op=%h a=%h b=%h imm=%h dest=%0d ill=%b, expected none",
                   g.opcode, g.a, g.b, g.imm, g.dest, g.illegal);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            n_bad++;
            $display("FAIL bundle: got op=%h fn=%h sh=%h a=%h b=%h imm=%h dest=%0d ill=%b, expected op=%h fn=%h sh=%h a=%h b=%h imm=%h dest=%0d ill=%b",
                     g.opcode, g.funct, g.shamt, g.a, g.b, g.imm, g.dest, g.illegal,
                     e.opcode, e.funct, e.shamt, e.a, e.b, e.imm, e.dest, e.illegal);
          end else begin
            $display("issue op=%h a=%h b=%h imm=%h dest=%0d ill=%b ok",
                     g.opcode, g.a, g.b, g.imm, g.dest, g.illegal);
          end
        end
      end
    end
  endtask

  // Drives one instruction until accepted; checks the number of stalled cycles.
  task automatic send(input string name, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                      input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] dest, input logic ill, input int exp_stalls);
    int stalls = 0;
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.rs       = rs;
    bus.rt       = rt;
    bus.rd       = rd;
    bus.shamt    = sh;
    bus.funct    = fn;
    while (!done) begin
      @(negedge clock);
      if (bus.in_ready) begin
        expect_bundle(op, rd, sh, fn, a, b, dest, ill);
        @(posedge clock);
        #1;
        done = 1'b1;
      end else begin
        stalls++;
        if (stalls > 20) begin
          n_vec++;
          n_bad++;
          $display("FAIL %s_timeout: got no accept after %0d cycles, expected accept", name, stalls);
          @(posedge clock);
          #1;
          done = 1'b1;
        end
      end
    end
    bus.in_valid = 1'b0;
    check({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
  endtask

  task automatic itype(input string name, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [15:0] imm16, input logic [31:0] a,
                       input logic [4:0] dest, input int exp_stalls);
    send(name, op, rs, rt, imm16[15:11], imm16[10:6], imm16[5:0], a, 32'h0, dest, 1'b0, exp_stalls);
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
    @(posedge clock);
    #1;
    bus.wb_en   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.opcode   = 6'h0;
    bus.rs       = 5'd0;
    bus.rt       = 5'd0;
    bus.rd       = 5'd0;
    bus.shamt    = 5'd0;
    bus.funct    = 6'h0;
    bus.wb_en    = 1'b0;
    bus.wb_addr  = 5'd0;
    bus.wb_data  = 32'h0;
    bus.ex_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_ex_imm", bus.ex_imm, 32'd0);
    tick();

    // Reset while a bundle is held: outputs, registers and scoreboard all clear.
    wb(5'd4, 32'h0000_1234);
    bus.ex_ready = 1'b0;
    itype("ori_r6", OP_ORI, 5'd0, 5'd6, 16'h0001, 32'h0, 5'd6, 0);
    check("held_ex_valid", 32'(bus.ex_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("midrst_ex_dest", 32'(bus.ex_dest), 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    bus.ex_ready = 1'b1;
    @(negedge clock);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    send("add_r7_r4_r6", OP_RTYPE, 5'd4, 5'd6, 5'd7, 5'd0, 6'h20, 32'h0, 32'h0, 5'd7, 1'b0, 0);

    // ADDI sign extension, then RAW on r1 resolved by writeback.
    itype("addi_r1", OP_ADDI, 5'd0, 5'd1, 16'hFFFF, 32'h0, 5'd1, 0);
    fork
      send("add_r2_r1_r1", OP_RTYPE, 5'd1, 5'd1, 5'd2, 5'd0, 6'h20, 32'h5, 32'h5, 5'd2, 1'b0, WB_STALLS);
      begin
        tick();
        tick();
        wb(5'd1, 32'h5);
      end
    join

    // Backpressure: held ORI stays stable while ANDI waits.
    tick();
    bus.ex_ready = 1'b0;
    itype("ori_r8", OP_ORI, 5'd0, 5'd8, 16'h00F0, 32'h0, 5'd8, 0);
    bus.in_valid = 1'b1;
    bus.opcode   = OP_ANDI;
    bus.rs       = 5'd0;
    bus.rt       = 5'd9;
    bus.rd       = 5'd1;
    bus.shamt    = 5'h1C;
    bus.funct    = 6'h0F;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_ex_valid", 32'(bus.ex_valid), 32'd1);
      check("bp_ex_dest", 32'(bus.ex_dest), 32'd8);
      check("bp_ex_imm", bus.ex_imm, 32'h0000_00F0);
      check("bp_ex_opcode", 32'(bus.ex_opcode), 32'(OP_ORI));
      tick();
    end
    bus.ex_ready = 1'b1;
    @(negedge clock);
    check("bp_resume_in_ready", 32'(bus.in_ready), 32'd1);
    expect_bundle(OP_ANDI, 5'd1, 5'h1C, 6'h0F, 32'h0, 32'h0, 5'd9, 1'b0);
    tick();
    bus.in_valid = 1'b0;

    // r0 write ignored; illegal opcode never stalls despite pending r2/r8/r9.
    wb(5'd0, 32'h0000_DEAD);
    send("illegal_3f", 6'h3F, 5'd2, 5'd8, 5'd9, 5'd0, 6'h00, 32'h0, 32'h0, 5'd0, 1'b1, 0);
    send("add_r10_r0_r0", OP_RTYPE, 5'd0, 5'd0, 5'd10, 5'd0, 6'h20, 32'h0, 32'h0, 5'd10, 1'b0, 0);

    // WAW on r3, then independent ops back to back.
    itype("lw_r3", OP_LW, 5'd0, 5'd3, 16'h0004, 32'h0, 5'd3, 0);
    fork
      itype("ori_r3_waw", OP_ORI, 5'd0, 5'd3, 16'h0001, 32'h0, 5'd3, WB_STALLS);
      begin
        tick();
        tick();
        wb(5'd3, 32'h77);
      end
    join
    itype("addi_r11", OP_ADDI, 5'd0, 5'd11, 16'h0007, 32'h0, 5'd11, 0);
    itype("addi_r12", OP_ADDI, 5'd0, 5'd12, 16'h0008, 32'h0, 5'd12, 0);
    itype("addi_r13", OP_ADDI, 5'd0, 5'd13, 16'h0009, 32'h0, 5'd13, 0);

    // Stores and branches read both sources and have no destination.
    wb(5'd4, 32'h0000_1234);
    send("sw_r1_r4", OP_SW, 5'd4, 5'd1, 5'd0, 5'd0, 6'h08, 32'h0000_1234, 32'h5, 5'd0, 1'b0, 0);
    send("beq_r1_r4", OP_BEQ, 5'd1, 5'd4, 5'h10, 5'd0, 6'h00, 32'h5, 32'h0000_1234, 5'd0, 1'b0, 0);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
